carry_lookahead_adder: RTL and testbench
========================================

// Module: carry_lookahead_adder
// PURPOSE
// - Registered WIDTH-bit unsigned/two's-complement adder built from carry-lookahead logic, no ripple chain.
// - Used as the fast add path next to the ALU.
// - Produces sum_o = oper1_i + oper2_i (mod 2^WIDTH), one clock after the operands are sampled.
// PARAMETERS
// - WIDTH  32  operand/sum width; must be a multiple of 4 (elaboration error otherwise)
// PORTS
// - clk_i    in   1      single clock, rising-edge active
// - rst_i    in   1      asynchronous reset, active-high
// - oper1_i  in   WIDTH  operand A
// - oper2_i  in   WIDTH  operand B
// - sum_o    out  WIDTH  registered sum A+B, truncated to WIDTH bits
// BEHAVIOUR
// - Reset: rst_i high clears sum_o to 0 immediately, without waiting for a clock edge. sum_o holds 0 while rst_i is high.
//   The first capture occurs on the first rising clk_i edge after rst_i falls.
// - Per-bit terms: g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i].
// - 4-bit CLA groups, carry-in 0 for group 0:
//   - c[i+1] = g[i] | p[i]&c[i], expanded to two-level sum-of-products.
//   - Each group exports a group generate G and a group propagate P.
// - Second-level lookahead unit:
//   - Computes the group carry-ins from G/P, using 4-group lookahead blocks.
//   - Levels are cascaded for WIDTH > 16.
// - Sum bits: s[i] = p[i] ^ c[i]. The final carry-out is computed and discarded unless CARRY_OUT_EN is defined.
// - Latency: 1 clk_i cycle.
//   - sum_o updates on every rising edge with the operands present at that edge.
//   - Throughput is 1 result per cycle. There is no handshake and no enable.
// - Wrap-around: any overflow is truncated modulo 2^WIDTH, e.g. 32'hFFFF_FFFF + 1 = 0.
// - The combinational path must not use the '+' operator; the carry logic is explicit.
// - Operand changes between edges never affect sum_o until the next edge.
// - Reset asserted mid-stream: sum_o goes to 0 asynchronously, and any in-flight result is lost.
// CONFIGURATION
// - CARRY_OUT_EN: when defined, two extra outputs are added, both registered alongside sum_o and reset to 0:
//   - carry_o, 1 bit: unsigned carry-out of the MSB.
//   - overflow_o, 1 bit: signed overflow = c[WIDTH] ^ c[WIDTH-1].
// - When CARRY_OUT_EN is undefined, neither port exists and the carry-out is unused.
// TESTING
// - Reset: rst_i=1 with operands 5,7 and clk_i running -> sum_o=0. After release, next edge -> sum_o=12.
// - Small sums, one pair per cycle:
//   - 1+1 -> 2
//   - 6+4 -> 10
//   - 15+1 -> 16 (group-0 carry into group 1)
//   - 31+5 -> 36
//   - 9+2 -> 11
//   - 4+4 -> 8
// - Long propagate: 32'h0000_FFFF+1 -> 32'h0001_0000, and 32'h7FFF_FFFF+1 -> 32'h8000_0000.
//   With CARRY_OUT_EN, the second case gives overflow_o=1.
// - Wrap-around: 32'hFFFF_FFFF+1 -> 0. With CARRY_OUT_EN, carry_o=1.
// - Latency: change the operands mid-cycle -> sum_o is unchanged until the next rising edge, then shows the new sum.
// - Random: 10k random pairs compared against a golden (A+B) mod 2^32 delayed one cycle; zero mismatches.

Source files
------------

// File: rtl/carry_lookahead_adder.sv
// Registered WIDTH-bit adder built from two-level carry-lookahead logic.
// Bits are grouped by four; group generate/propagate terms feed a tree of
// 4-way lookahead blocks (one level per factor of four groups). The tree
// produces every group carry-in, so no carry ever ripples between groups.
// Optional feature macro: CARRY_OUT_EN adds registered carry_o and overflow_o.
module carry_lookahead_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] oper1_i,
  input  logic [WIDTH-1:0] oper2_i,
  output logic [WIDTH-1:0] sum_o
`ifdef CARRY_OUT_EN
  ,
  output logic             carry_o,
  output logic             overflow_o
`endif
);

  // Number of lookahead levels needed above the 4-bit groups.
  function automatic int unsigned calc_levels(input int unsigned n);
    int unsigned cnt;
    int unsigned rem;
    cnt = 0;
    rem = n;
    while (rem > 1) begin
      rem = (rem + 3) / 4;
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  localparam int unsigned NumGroups = WIDTH / 4;
  localparam int unsigned Levels    = calc_levels(NumGroups);
  // Level 0 is padded to a power of four so every tree node has four children.
  localparam int unsigned NumPad    = 1 << (2 * Levels);

  if ((WIDTH % 4) != 0 || WIDTH == 0) begin : g_width_check
    $error("carry_lookahead_adder: WIDTH must be a non-zero multiple of 4");
  end

  // Carries into positions 0..3 of a 4-wide block, flattened to sum-of-products.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // Block generate: the block produces a carry-out regardless of its carry-in.
  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Block propagate: a carry-in passes straight through all four positions.
  function automatic logic cla4_prop(input logic [3:0] p);
    return &p;
  endfunction

  logic [WIDTH-1:0]               w_g;
  logic [WIDTH-1:0]               w_p;
  logic [WIDTH-1:0]               w_c;
  logic [WIDTH-1:0]               w_sum;
  logic                           w_cout;
  logic [Levels:0][NumPad-1:0]    w_lvl_g;
  logic [Levels:0][NumPad-1:0]    w_lvl_p;
  logic [Levels:0][NumPad-1:0]    w_lvl_c;
  logic                           w_unused_tree;
  logic [WIDTH-1:0]               r_sum;

  assign w_g = oper1_i & oper2_i;
  assign w_p = oper1_i ^ oper2_i;

  // Upward pass: group G/P at level 0, then combine four nodes per level.
  always_comb begin
    w_lvl_g = '0;
    w_lvl_p = '0;
    for (int unsigned i = 0; i < NumGroups; i++) begin
      w_lvl_g[0][i] = cla4_gen(w_g[4*i +: 4], w_p[4*i +: 4]);
      w_lvl_p[0][i] = cla4_prop(w_p[4*i +: 4]);
    end
    for (int unsigned k = 1; k <= Levels; k++) begin
      for (int unsigned j = 0; j < NumPad / 4; j++) begin
        w_lvl_g[k][j] = cla4_gen(w_lvl_g[k-1][4*j +: 4], w_lvl_p[k-1][4*j +: 4]);
        w_lvl_p[k][j] = cla4_prop(w_lvl_p[k-1][4*j +: 4]);
      end
    end
  end

  // Downward pass: root carry-in is 0; each node hands carries to its children.
  always_comb begin
    w_lvl_c = '0;
    for (int unsigned k = Levels; k > 0; k--) begin
      for (int unsigned j = 0; j < NumPad / 4; j++) begin
        w_lvl_c[k-1][4*j +: 4] = cla4_carry(w_lvl_g[k-1][4*j +: 4],
                                            w_lvl_p[k-1][4*j +: 4],
                                            w_lvl_c[k][j]);
      end
    end
  end

  // Bit-level carries inside each group from its lookahead carry-in.
  always_comb begin
    w_c = '0;
    for (int unsigned i = 0; i < NumGroups; i++) begin
      w_c[4*i +: 4] = cla4_carry(w_g[4*i +: 4], w_p[4*i +: 4], w_lvl_c[0][i]);
    end
    w_cout = cla4_gen(w_g[WIDTH-1 -: 4], w_p[WIDTH-1 -: 4])
           | (cla4_prop(w_p[WIDTH-1 -: 4]) & w_lvl_c[0][NumGroups-1]);
  end

  assign w_sum = w_p ^ w_c;

  // Result register; reset clears it without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum;
    end
  end

  assign sum_o = r_sum;

`ifdef CARRY_OUT_EN
  logic r_carry;
  logic r_overflow;

  // Flag registers captured on the same edge as the sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_carry    <= w_cout;
      r_overflow <= w_cout ^ w_c[WIDTH-1];
    end
  end

  assign carry_o    = r_carry;
  assign overflow_o = r_overflow;

  // Padding nodes and the root G/P have no consumer.
  assign w_unused_tree = ^{w_lvl_g, w_lvl_p, w_lvl_c};
`else
  // Padding nodes, the root G/P and the final carry-out have no consumer.
  assign w_unused_tree = ^{w_lvl_g, w_lvl_p, w_lvl_c, w_cout};
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench for carry_lookahead_adder: a scoreboard queue holds
// golden results pushed when operands are driven, popped one edge later.
module tb_carry_lookahead_adder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
`ifdef CARRY_OUT_EN
  logic         carry;
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         last_exp;
  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  carry_lookahead_adder #(
    .WIDTH(W)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .oper1_i   (a),
    .oper2_i   (b),
    .sum_o     (sum)
`ifdef CARRY_OUT_EN
    ,
    .carry_o   (carry),
    .overflow_o(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  function automatic exp_t golden(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] full;
    exp_t       e;
    full    = {1'b0, x} + {1'b0, y};
    e.sum   = full[W-1:0];
    e.carry = full[W];
    e.ovf   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    sb_q.push_back(golden(x, y));
  endtask

  task automatic compare_out(input string tag);
    check_eq({tag, ":depth"}, W'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      last_exp = sb_q.pop_front();
      check_eq({tag, ":sum"}, sum, last_exp.sum);
`ifdef CARRY_OUT_EN
      check_eq({tag, ":carry"}, W'(carry), W'(last_exp.carry));
      check_eq({tag, ":ovf"}, W'(ovf), W'(last_exp.ovf));
`endif
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    drive(x, y);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  logic [W-1:0] small_a [6] = '{32'd1, 32'd6, 32'd15, 32'd31, 32'd9, 32'd4};
  logic [W-1:0] small_b [6] = '{32'd1, 32'd4, 32'd1,  32'd5,  32'd2, 32'd4};

  initial begin
    rst = 1'b1;
    a   = 32'd5;
    b   = 32'd7;
    #1;
    check_eq("reset_async_init", sum, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", sum, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(golden(32'd5, 32'd7));
    @(posedge clk);
    #1;
    compare_out("reset_release");

    for (int i = 0; i < 6; i++) begin
      step("small", small_a[i], small_b[i]);
    end

    step("prop16", 32'h0000_FFFF, 32'd1);
    step("prop_msb", 32'h7FFF_FFFF, 32'd1);
    step("wrap", 32'hFFFF_FFFF, 32'd1);
    step("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("neg_ovf", 32'h8000_0000, 32'h8000_0000);

    // Operands changed between edges must not disturb the registered sum.
    step("lat_base", 32'h0000_0100, 32'h0000_0023);
    #2;
    a = 32'h1234_0000;
    b = 32'h0000_5678;
    #1;
    check_eq("lat_hold", sum, last_exp.sum);
    sb_q.push_back(golden(32'h1234_0000, 32'h0000_5678));
    @(posedge clk);
    #1;
    compare_out("lat_next");

    // Reset mid-stream: sum clears at once and the in-flight result is dropped.
    @(negedge clk);
    a = 32'h0F0F_0F0F;
    b = 32'h0101_0101;
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_async", sum, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_mid_hold", sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      step("rand", $urandom, $urandom);
    end

    check_eq("sb_drain", W'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
